// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : RV32I fetch stage. Owns PCF, keeps one imem request in flight,
//               buffers one response and drives the IF/ID register.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stallF,
    input  logic            stallD,
    input  logic            flushF,
    input  logic            flushD,
    input  logic            PCSrcE,
    input  logic [XLEN-1:0] PCTargetE,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic            validD
);

    localparam logic [1:0] S_REQ  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_FULL = 2'd2;

    localparam logic [XLEN-1:0] c_four = XLEN'(4);

    logic [1:0]      r_state;
    logic [XLEN-1:0] r_pcF;
    logic [XLEN-1:0] r_reqPc;
    logic            r_kill;
    logic            r_bufValid;
    logic [31:0]     r_bufInstr;
    logic [XLEN-1:0] r_bufPc;
    logic [31:0]     r_instrD;
    logic [XLEN-1:0] r_pcD;
    logic [XLEN-1:0] r_pcPlus4D;
    logic            r_validD;

    logic            w_redirect;
    logic            w_drop;
    logic            w_req;
    logic            w_gnt;
    logic            w_advance;

    assign w_redirect = PCSrcE;
    assign w_drop     = PCSrcE | flushF;
    // Request is gated by rst so nothing is issued during the reset cycle.
    assign w_req      = (r_state == S_REQ) & ~stallF & ~rst;
    assign w_gnt      = w_req & imem_gnt;
    assign w_advance  = r_bufValid & ~stallD & ~stallF & ~w_drop;

    assign imem_req  = w_req;
    assign imem_addr = r_pcF;
    assign InstrD    = r_instrD;
    assign PCD       = r_pcD;
    assign PCPlus4D  = r_pcPlus4D;
    assign validD    = r_validD;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_REQ;
            r_pcF      <= RESET_PC;
            r_reqPc    <= '0;
            r_kill     <= 1'b0;
            r_bufValid <= 1'b0;
            r_bufInstr <= NOP_INSTR;
            r_bufPc    <= '0;
        end else begin
            // A redirect always wins over the sequential +4 step.
            if (w_redirect) begin
                r_pcF <= PCTargetE;
            end else if (w_gnt) begin
                r_pcF <= r_pcF + c_four;
            end

            case (r_state)
                S_REQ: begin
                    if (w_gnt) begin
                        r_state <= S_WAIT;
                        r_reqPc <= r_pcF;
                        r_kill  <= w_drop;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        if (!r_kill && !w_drop) begin
                            r_bufInstr <= imem_rdata;
                            r_bufPc    <= r_reqPc;
                            r_bufValid <= 1'b1;
                            r_state    <= S_FULL;
                        end else begin
                            r_kill  <= 1'b0;
                            r_state <= S_REQ;
                        end
                    end else if (w_drop) begin
                        r_kill <= 1'b1;
                    end
                end
                S_FULL: begin
                    if (w_advance || w_drop) begin
                        r_bufValid <= 1'b0;
                        r_state    <= S_REQ;
                    end
                end
                default: begin
                    r_state    <= S_REQ;
                    r_bufValid <= 1'b0;
                    r_kill     <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_instrD   <= NOP_INSTR;
            r_pcD      <= '0;
            r_pcPlus4D <= '0;
            r_validD   <= 1'b0;
        end else if (flushD) begin
            r_instrD <= NOP_INSTR;
            r_validD <= 1'b0;
        end else if (stallD) begin
            r_instrD <= r_instrD;
        end else if (w_advance) begin
            r_instrD   <= r_bufInstr;
            r_pcD      <= r_bufPc;
            r_pcPlus4D <= r_bufPc + c_four;
            r_validD   <= 1'b1;
        end else begin
            r_instrD <= NOP_INSTR;
            r_validD <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Directed and randomized bench for fetch_unit with a
//               transaction-level reference model and a simple memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst, stallF, stallD, flushF, flushD, PCSrcE;
    logic [31:0] PCTargetE;
    logic        imem_req, imem_gnt, imem_rvalid, validD;
    logic [31:0] imem_addr, imem_rdata, InstrD, PCD, PCPlus4D;

    fetch_unit dut (
        .clk(clk), .rst(rst), .stallF(stallF), .stallD(stallD),
        .flushF(flushF), .flushD(flushD), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .validD(validD)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // stimulus controls for the next cycle
    bit          cRst, cStallF, cStallD, cFlushF, cFlushD, cPcSrc, cGntEn, cSpur;
    logic [31:0] cTgt;
    int          cDelay;

    // memory responder
    bit          memPend = 0;
    logic [31:0] memAddr;
    int          memDelay;

    // reference model: fetch PC, at most one fetch in flight, a response queue,
    // and the decode-side register contents
    typedef struct { logic [31:0] instr; logic [31:0] pc; } ent_t;
    ent_t        mBuf[$];
    logic [31:0] mPc = 0, mReqPc = 0;
    bit          mOut = 0, mKill = 0;
    logic [31:0] mInstrD = NOP, mPcD = 0, mPcP4D = 0;
    bit          mValidD = 0;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        cRst = 0; cStallF = 0; cStallD = 0; cFlushF = 0; cFlushD = 0;
        cPcSrc = 0; cTgt = 32'h0; cSpur = 0;
    endtask

    task automatic step();
        bit          expReq, g, rv, drop, has, adv;
        logic [31:0] rd, nextPc;
        ent_t        e;
        rst = cRst; stallF = cStallF; stallD = cStallD; flushF = cFlushF;
        flushD = cFlushD; PCSrcE = cPcSrc; PCTargetE = cTgt;
        rv = (memPend && memDelay == 0) || (cSpur && !memPend);
        rd = memPend ? memWord(memAddr) : $urandom;
        imem_rvalid = rv;
        imem_rdata  = rd;
        expReq = !cRst && !mOut && mBuf.size() == 0 && !cStallF;
        g = expReq && !memPend && cGntEn;
        imem_gnt = g;
        #1;
        chk("imem_req", {31'b0, imem_req}, {31'b0, expReq});
        if (expReq) chk("imem_addr", imem_addr, mPc);
        @(posedge clk);
        // memory side
        if (memPend && memDelay == 0) memPend = 0;
        else if (memPend) memDelay--;
        if (g) begin memPend = 1; memAddr = mPc; memDelay = cDelay; end
        // model side
        if (cRst) begin
            mPc = 32'h0; mOut = 0; mKill = 0; mBuf.delete();
            mInstrD = NOP; mPcD = 0; mPcP4D = 0; mValidD = 0;
        end else begin
            drop = cPcSrc || cFlushF;
            has  = mBuf.size() > 0;
            adv  = has && !cStallD && !cStallF && !drop;
            if (cFlushD) begin
                mInstrD = NOP; mValidD = 0;
            end else if (cStallD) begin
            end else if (adv) begin
                mInstrD = mBuf[0].instr; mPcD = mBuf[0].pc;
                mPcP4D = mBuf[0].pc + 32'd4; mValidD = 1;
            end else begin
                mInstrD = NOP; mValidD = 0;
            end
            nextPc = mPc;
            if (g) begin
                mOut = 1; mReqPc = mPc; mKill = drop; nextPc = mPc + 32'd4;
            end else if (mOut) begin
                if (rv) begin
                    if (!(mKill || drop)) begin
                        e.instr = rd; e.pc = mReqPc; mBuf.push_back(e);
                    end
                    mKill = 0; mOut = 0;
                end else if (drop) begin
                    mKill = 1;
                end
            end else if (has && (adv || drop)) begin
                void'(mBuf.pop_front());
            end
            if (cPcSrc) nextPc = cTgt;
            mPc = nextPc;
        end
        #1;
        chk("InstrD", InstrD, mInstrD);
        chk("PCD", PCD, mPcD);
        chk("PCPlus4D", PCPlus4D, mPcP4D);
        chk("validD", {31'b0, validD}, {31'b0, mValidD});
    endtask

    initial begin
        idle(); cGntEn = 1; cDelay = 0;
        // reset
        cRst = 1; step();
        chk("rst_instr", InstrD, NOP);
        chk("rst_pcd", PCD, 32'h0);
        chk("rst_valid", {31'b0, validD}, 32'h0);
        cRst = 0;
        // first fetch: gnt immediately, response one cycle later
        step(); step(); step();
        chk("t1_instr", InstrD, 32'h0050_0093);
        chk("t1_pcd", PCD, 32'h0);
        chk("t1_valid", {31'b0, validD}, 32'h1);
        chk("t1_next_addr", imem_addr, 32'h4);
        chk("t1_next_req", {31'b0, imem_req}, 32'h1);
        // straight-line fetches
        step(); step(); step();
        chk("t2_pcd4", PCD, 32'h4);
        chk("t2_instr4", InstrD, memWord(32'h4));
        step(); step(); step();
        chk("t2_pcd8", PCD, 32'h8);
        chk("t2_p4_8", PCPlus4D, 32'hC);
        // stall with a full buffer
        step(); step();
        cStallF = 1; cStallD = 1;
        step();
        chk("t3_hold_pcd", PCD, 32'h8);
        chk("t3_req", {31'b0, imem_req}, 32'h0);
        step();
        chk("t3_hold_pcd2", PCD, 32'h8);
        chk("t3_hold_valid", {31'b0, validD}, 32'h0);
        idle(); step();
        chk("t3_rel_pcd", PCD, 32'hC);
        chk("t3_rel_instr", InstrD, memWord(32'hC));
        chk("t3_rel_valid", {31'b0, validD}, 32'h1);
        // redirect while waiting
        cDelay = 2; step();
        cDelay = 0; cPcSrc = 1; cTgt = 32'h100; step();
        chk("t4_valid_p", {31'b0, validD}, 32'h0);
        idle(); step(); step();
        chk("t4_addr", imem_addr, 32'h100);
        chk("t4_valid_r", {31'b0, validD}, 32'h0);
        step(); step(); step();
        chk("t4_pcd", PCD, 32'h100);
        chk("t4_instr", InstrD, memWord(32'h100));
        // redirect together with gnt
        chk("t5_pre_addr", imem_addr, 32'h104);
        cPcSrc = 1; cTgt = 32'h100; step();
        idle();
        chk("t5_wait_req", {31'b0, imem_req}, 32'h0);
        step();
        chk("t5_addr", imem_addr, 32'h100);
        chk("t5_valid", {31'b0, validD}, 32'h0);
        step(); step();
        // flushD with a full buffer (stallD keeps the buffer)
        cFlushD = 1; cStallD = 1; step();
        chk("t6_flush_instr", InstrD, NOP);
        chk("t6_flush_valid", {31'b0, validD}, 32'h0);
        idle(); step();
        chk("t6_kept_instr", InstrD, memWord(32'h100));
        chk("t6_kept_pcd", PCD, 32'h100);
        // reset in the middle of a transaction, response arrives late
        cDelay = 2; step();
        cDelay = 0; cRst = 1; step();
        chk("t6_rst_valid", {31'b0, validD}, 32'h0);
        cRst = 0; step(); step();
        chk("t6_late_valid", {31'b0, validD}, 32'h0);
        chk("t6_late_addr", imem_addr, 32'h0);
        step(); step(); step();
        chk("t6_refetch", InstrD, 32'h0050_0093);
        // wrap of PCF at the top of the address space
        cPcSrc = 1; cTgt = 32'hFFFF_FFFC; step(); idle();
        for (int i = 0; i < 8; i++) step();
        // randomized phase
        for (int i = 0; i < 4000; i++) begin
            cRst    = ($urandom_range(0, 199) == 0);
            cStallF = ($urandom_range(0, 4) == 0);
            cStallD = ($urandom_range(0, 4) == 0);
            cFlushF = ($urandom_range(0, 19) == 0);
            cFlushD = ($urandom_range(0, 19) == 0);
            cPcSrc  = ($urandom_range(0, 14) == 0);
            cTgt    = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
            cGntEn  = ($urandom_range(0, 9) < 7);
            cSpur   = ($urandom_range(0, 29) == 0);
            cDelay  = $urandom_range(0, 3);
            step();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
